// File: rtl/bbox_sample_iter_pkg.sv
// Shared types and helpers for the bounding-box sample iterator.
// Holds the walker state encoding, box corner indices and the subsample step decode.
package bbox_sample_iter_pkg;

    typedef enum logic {
        WAIT = 1'b0,
        TEST = 1'b1
    } state_t;

    localparam int LL = 0;
    localparam int UR = 1;

    // One-hot sample rate to grid step in fixed point; illegal codes fall back to one per pixel.
    function automatic logic [31:0] step_from_subsample(input logic [3:0] sub_sample,
                                                        input int radix);
        logic [31:0] step;
        case (sub_sample)
            4'b1000: step = 32'd1 << radix;
            4'b0100: step = 32'd1 << (radix - 1);
            4'b0010: step = 32'd1 << (radix - 2);
            4'b0001: step = 32'd1 << (radix - 3);
            default: step = 32'd1 << radix;
        endcase
        return step;
    endfunction

endpackage

// File: rtl/bbox_next_sample.sv
// Raster-order successor of a sample location inside a snapped bounding box,
// plus a flag marking the final (upper-right) location.
module bbox_next_sample #(
    parameter int SIGFIG = 24
) (
    input  logic signed [SIGFIG-1:0] cur_x,
    input  logic signed [SIGFIG-1:0] cur_y,
    input  logic signed [SIGFIG-1:0] ll_x,
    input  logic signed [SIGFIG-1:0] ur_x,
    input  logic signed [SIGFIG-1:0] ur_y,
    input  logic signed [SIGFIG-1:0] step,
    output logic signed [SIGFIG-1:0] next_x,
    output logic signed [SIGFIG-1:0] next_y,
    output logic                     last
);

    always_comb begin
        next_x = cur_x + step;
        next_y = cur_y;
        // End of row: wrap back to the left edge and move up one step.
        if (cur_x == ur_x) begin
            next_x = ll_x;
            next_y = cur_y + step;
        end
        last = (cur_x == ur_x) && (cur_y == ur_y);
    end

endmodule

// File: rtl/bbox_sample_iter.sv
// Walks one triangle's bounding box in raster order, one subsample per cycle,
// halting the bounding-box stage while the walk is in progress.
module bbox_sample_iter
    import bbox_sample_iter_pkg::*;
#(
    parameter int SIGFIG = 24,
    parameter int RADIX  = 10,
    parameter int VERTS  = 3,
    parameter int AXIS   = 3,
    parameter int COLORS = 3
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R13S,
    input  logic        [COLORS-1:0][SIGFIG-1:0]          color_R13U,
    input  logic signed [1:0][1:0][SIGFIG-1:0]            box_R13S,
    input  logic                                          validTri_R13H,
    input  logic        [3:0]                             subSample_RnnnnU,
    output logic                                          halt_RnnnnL,
    output logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R14S,
    output logic        [COLORS-1:0][SIGFIG-1:0]          color_R14U,
    output logic signed [1:0][SIGFIG-1:0]                 sample_R14S,
    output logic                                          validSamp_R14H
);

    state_t state_p0;
    state_t state_nxt;

    logic signed [SIGFIG-1:0] ll_x_p0;
    logic signed [SIGFIG-1:0] ur_x_p0;
    logic signed [SIGFIG-1:0] ur_y_p0;
    logic signed [SIGFIG-1:0] step_p0;
    logic signed [SIGFIG-1:0] step_in;
    logic signed [SIGFIG-1:0] next_x;
    logic signed [SIGFIG-1:0] next_y;
    logic                     last;

    assign step_in = SIGFIG'(step_from_subsample(subSample_RnnnnU, RADIX));

    bbox_next_sample #(
        .SIGFIG(SIGFIG)
    ) u_next (
        .cur_x (sample_R14S[0]),
        .cur_y (sample_R14S[1]),
        .ll_x  (ll_x_p0),
        .ur_x  (ur_x_p0),
        .ur_y  (ur_y_p0),
        .step  (step_p0),
        .next_x(next_x),
        .next_y(next_y),
        .last  (last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_p0 <= WAIT;
        end else begin
            state_p0 <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_p0;
        case (state_p0)
            WAIT:    if (validTri_R13H) state_nxt = TEST;
            TEST:    if (last)          state_nxt = WAIT;
            default: state_nxt = WAIT;
        endcase
    end

    // Both handshake outputs decode directly from the state flop.
    always_comb begin
        halt_RnnnnL    = (state_p0 == WAIT);
        validSamp_R14H = (state_p0 == TEST);
    end

    // Triangle, colour and box corners are captured on accept; the sample advances each TEST cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            tri_R14S    <= '0;
            color_R14U  <= '0;
            sample_R14S <= '0;
            ll_x_p0     <= '0;
            ur_x_p0     <= '0;
            ur_y_p0     <= '0;
            step_p0     <= '0;
        end else if (state_p0 == WAIT) begin
            if (validTri_R13H) begin
                tri_R14S       <= tri_R13S;
                color_R14U     <= color_R13U;
                sample_R14S[0] <= box_R13S[LL][0];
                sample_R14S[1] <= box_R13S[LL][1];
                ll_x_p0        <= box_R13S[LL][0];
                ur_x_p0        <= box_R13S[UR][0];
                ur_y_p0        <= box_R13S[UR][1];
                step_p0        <= step_in;
            end
        end else begin
            sample_R14S[0] <= next_x;
            sample_R14S[1] <= next_y;
        end
    end

endmodule

// File: tb/tb_bbox_sample_iter.sv
// Self-checking bench for bbox_sample_iter: directed table, held-valid and reset
// corner sequences, and random boxes against a raster-order reference model.
module tb_bbox_sample_iter;

    localparam int SIGFIG = 24;
    localparam int RADIX  = 10;
    localparam int VERTS  = 3;
    localparam int AXIS   = 3;
    localparam int COLORS = 3;

    typedef logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_t;
    typedef logic [COLORS-1:0][SIGFIG-1:0]          col_t;

    typedef struct {
        int         llx;
        int         lly;
        int         urx;
        int         ury;
        logic [3:0] ss;
        int         exp_n;
    } vec_t;

    logic                          clk = 1'b0;
    logic                          rst;
    tri_t                          tri_R13S;
    col_t                          color_R13U;
    logic [1:0][1:0][SIGFIG-1:0]   box_R13S;
    logic                          validTri_R13H;
    logic [3:0]                    subSample_RnnnnU;
    logic                          halt_RnnnnL;
    tri_t                          tri_R14S;
    col_t                          color_R14U;
    logic [1:0][SIGFIG-1:0]        sample_R14S;
    logic                          validSamp_R14H;

    int total = 0;
    int bad   = 0;
    int exp_x[$];
    int exp_y[$];

    always #5 clk = ~clk;

    bbox_sample_iter #(
        .SIGFIG(SIGFIG), .RADIX(RADIX), .VERTS(VERTS), .AXIS(AXIS), .COLORS(COLORS)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .tri_R13S        (tri_R13S),
        .color_R13U      (color_R13U),
        .box_R13S        (box_R13S),
        .validTri_R13H   (validTri_R13H),
        .subSample_RnnnnU(subSample_RnnnnU),
        .halt_RnnnnL     (halt_RnnnnL),
        .tri_R14S        (tri_R14S),
        .color_R14U      (color_R14U),
        .sample_R14S     (sample_R14S),
        .validSamp_R14H  (validSamp_R14H)
    );

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic int step_of(input logic [3:0] ss);
        case (ss)
            4'b1000: return 1024;
            4'b0100: return 512;
            4'b0010: return 256;
            default: return 128;
        endcase
    endfunction

    // Reference: every grid point of the box, rows bottom to top, left to right.
    task automatic build_model(input int llx, input int lly, input int urx, input int ury,
                               input logic [3:0] ss);
        int st;
        st = step_of(ss);
        exp_x.delete();
        exp_y.delete();
        for (int y = lly; y <= ury; y += st)
            for (int x = llx; x <= urx; x += st) begin
                exp_x.push_back(x);
                exp_y.push_back(y);
            end
    endtask

    task automatic drive_inputs(input int llx, input int lly, input int urx, input int ury,
                                input logic [3:0] ss, output tri_t tri_e, output col_t col_e);
        for (int v = 0; v < VERTS; v++)
            for (int a = 0; a < AXIS; a++)
                tri_R13S[v][a] = 24'($urandom);
        for (int c = 0; c < COLORS; c++)
            color_R13U[c] = 24'($urandom);
        box_R13S[0][0]   = 24'(llx);
        box_R13S[0][1]   = 24'(lly);
        box_R13S[1][0]   = 24'(urx);
        box_R13S[1][1]   = 24'(ury);
        subSample_RnnnnU = ss;
        validTri_R13H    = 1'b1;
        tri_e            = tri_R13S;
        col_e            = color_R13U;
    endtask

    task automatic start_box(input int llx, input int lly, input int urx, input int ury,
                             input logic [3:0] ss, output tri_t tri_e, output col_t col_e);
        @(negedge clk);
        drive_inputs(llx, lly, urx, ury, ss, tri_e, col_e);
        chk("halt_at_accept", halt_RnnnnL, 1'b1);
        @(posedge clk);
        #1 validTri_R13H = 1'b0;
    endtask

    // Checks n_exp consecutive samples (model length if n_exp < 0) and the bubble after.
    task automatic check_walk(input int llx, input int lly, input int urx, input int ury,
                              input logic [3:0] ss, input tri_t tri_e, input col_t col_e,
                              input int n_exp);
        int n;
        build_model(llx, lly, urx, ury, ss);
        n = (n_exp < 0) ? exp_x.size() : n_exp;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            chk("valid", validSamp_R14H, 1'b1);
            chk("halt_busy", halt_RnnnnL, 1'b0);
            chk("sample_x", sample_R14S[0], (k < exp_x.size()) ? 24'(exp_x[k]) : 24'hx);
            chk("sample_y", sample_R14S[1], (k < exp_y.size()) ? 24'(exp_y[k]) : 24'hx);
            chk("tri", tri_R14S, tri_e);
            chk("color", color_R14U, col_e);
        end
        @(negedge clk);
        chk("bubble_valid", validSamp_R14H, 1'b0);
        chk("bubble_halt", halt_RnnnnL, 1'b1);
    endtask

    vec_t vecs[4];

    initial begin
        tri_t tri_a, tri_b;
        col_t col_a, col_b;
        int   st, llx, lly, w, h;
        logic [3:0] ss;

        vecs[0] = '{0, 0, 2048, 1024, 4'b1000, 6};
        vecs[1] = '{512, 512, 1024, 1024, 4'b0100, 4};
        vecs[2] = '{3072, 2048, 3072, 2048, 4'b1000, 1};
        vecs[3] = '{-1024, -1024, 0, 0, 4'b1000, 4};

        rst              = 1'b1;
        validTri_R13H    = 1'b0;
        tri_R13S         = '0;
        color_R13U       = '0;
        box_R13S         = '0;
        subSample_RnnnnU = 4'b1000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_halt", halt_RnnnnL, 1'b1);
        chk("rst_valid", validSamp_R14H, 1'b0);
        chk("rst_sample", sample_R14S, '0);
        chk("rst_tri", tri_R14S, '0);
        chk("rst_color", color_R14U, '0);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            start_box(vecs[i].llx, vecs[i].lly, vecs[i].urx, vecs[i].ury, vecs[i].ss, tri_a, col_a);
            check_walk(vecs[i].llx, vecs[i].lly, vecs[i].urx, vecs[i].ury, vecs[i].ss,
                       tri_a, col_a, vecs[i].exp_n);
        end

        // Second triangle held valid during a walk: accepted right after the bubble.
        @(negedge clk);
        drive_inputs(0, 0, 1024, 1024, 4'b1000, tri_a, col_a);
        @(posedge clk);
        #1 drive_inputs(-2048, 1024, -1024, 1024, 4'b1000, tri_b, col_b);
        check_walk(0, 0, 1024, 1024, 4'b1000, tri_a, col_a, 4);
        @(posedge clk);
        #1 validTri_R13H = 1'b0;
        check_walk(-2048, 1024, -1024, 1024, 4'b1000, tri_b, col_b, 2);

        // Reset on the third sample abandons the box.
        start_box(0, 0, 2048, 1024, 4'b1000, tri_a, col_a);
        build_model(0, 0, 2048, 1024, 4'b1000);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("pre_rst_valid", validSamp_R14H, 1'b1);
            chk("pre_rst_x", sample_R14S[0], 24'(exp_x[k]));
        end
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid", validSamp_R14H, 1'b0);
        chk("mid_rst_halt", halt_RnnnnL, 1'b1);
        chk("mid_rst_sample", sample_R14S, '0);
        chk("mid_rst_tri", tri_R14S, '0);
        chk("mid_rst_color", color_R14U, '0);
        rst = 1'b0;
        @(negedge clk);
        chk("no_resume_valid", validSamp_R14H, 1'b0);

        for (int r = 0; r < 8; r++) begin
            ss  = 4'b0001 << $urandom_range(0, 3);
            st  = step_of(ss);
            llx = (int'($urandom_range(0, 16)) - 8) * st;
            lly = (int'($urandom_range(0, 16)) - 8) * st;
            w   = int'($urandom_range(0, 3));
            h   = int'($urandom_range(0, 3));
            start_box(llx, lly, llx + w * st, lly + h * st, ss, tri_a, col_a);
            check_walk(llx, lly, llx + w * st, lly + h * st, ss, tri_a, col_a, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bbox_sample_iter.md
# bbox_sample_iter

Walks the bounding box of one triangle in raster order, one subsample location per cycle, and hands each location with its triangle and colour to the jitter/hash stage that precedes the sample test. Sits between the bounding-box stage (R13) and the jitter stage (R14). It backpressures the bounding-box stage with an active-low halt while a box is being walked.

## Interface
Parameters:
- SIGFIG, 24, bits in colour and position
- RADIX, 10, fraction bits in colour and position
- VERTS, 3, vertices per triangle
- AXIS, 3, axes per vertex (x,y,z)
- COLORS, 3, colour channels

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock, synchronous, active-high
- tri_R13S  in  signed [SIGFIG-1:0] [VERTS][AXIS]  triangle
- color_R13U  in  unsigned [SIGFIG-1:0] [COLORS]  triangle colour
- box_R13S  in  signed [SIGFIG-1:0] [2][2]  box; [0]=lower-left, [1]=upper-right, each [x,y]
- validTri_R13H  in  1  triangle/box valid
- subSample_RnnnnU  in  4  one-hot sample rate: 1000=1/px, 0100=4/px, 0010=16/px, 0001=64/px
- halt_RnnnnL  out  1  low = busy; upstream must hold its inputs
- tri_R14S  out  as tri_R13S  latched triangle
- color_R14U  out  as color_R13U  latched colour
- sample_R14S  out  signed [SIGFIG-1:0] [2]  current sample (x,y)
- validSamp_R14H  out  1  sample_R14S valid

## Operation
- Step: 1000 -> 1<<RADIX; 0100 -> 1<<(RADIX-1); 0010 -> 1<<(RADIX-2); 0001 -> 1<<(RADIX-3). Non-one-hot values are illegal; sampling them is a bench error.
- subSample_RnnnnU is quasi-static. It is only changed while in WAIT.
- The box is snapped to the step grid upstream. LL <= UR on both axes is guaranteed.
- States:
  - WAIT:
    - halt_RnnnnL=1, validSamp_R14H=0.
    - On validTri_R13H: latch tri, colour and box UR; sample <= box LL; go to TEST.
  - TEST:
    - validSamp_R14H=1.
    - Next sample: if x != URx, then x += step. Otherwise x <= LLx and y += step.
    - Last sample is x==URx and y==URy. Go to WAIT after it.
- validTri_R13H while in TEST is ignored. Upstream is halted, so no triangle is lost.
- Degenerate box (LL==UR) yields exactly one sample.
- Adds are signed SIGFIG-bit. The box stays inside the screen, so no overflow handling is needed. Compares are exact equality on the snapped grid.
- Reset:
  - state=WAIT, halt_RnnnnL=1, validSamp_R14H=0.
  - All data outputs are 0.
  - Reset mid-walk abandons the box and does not resume it.

## Timing
- Triangle accepted at cycle t (validTri_R13H=1, halt_RnnnnL=1) gives first sample valid at t+1.
- N = ((URx-LLx)/step+1)·((URy-LLy)/step+1). Samples are valid on consecutive cycles t+1..t+N, with no gaps.
- halt_RnnnnL is a registered output:
  - 0 for cycles t+1..t+N.
  - 1 from t+N+1.
- The next triangle is accepted at t+N+1 at earliest. There is exactly one bubble between boxes.
- tri_R14S/color_R14U are stable for t+1..t+N.

## Structure
- Shared package holds:
  - the state enum {WAIT, TEST};
  - the step-from-subSample function;
  - the box index constants LL=0, UR=1.
- One natural sub-module, bbox_next_sample (combinational). It takes current sample, LL, UR and step, and returns next sample plus the last flag.
- The FSM and output registers stay in bbox_sample_iter.

## Test plan
- Box (0,0)-(2048,1024), subSample=1000 -> 6 samples over 6 cycles: (0,0),(1024,0),(2048,0),(0,1024),(1024,1024),(2048,1024). halt_RnnnnL is low for exactly those 6 cycles.
- Box (512,512)-(1024,1024), subSample=0100 -> 4 samples, in order (512,512),(1024,512),(512,1024),(1024,1024).
- Degenerate box (3072,2048)-(3072,2048) -> one sample, then halt_RnnnnL=1 the next cycle.
- Negative box (-1024,-1024)-(0,0), subSample=1000 -> (-1024,-1024),(0,-1024),(-1024,0),(0,0).
- Second validTri_R13H with a different box held during a walk -> the first box completes unchanged, then the second is accepted at t+N+1 with one bubble.
- rst asserted on the 3rd sample of a 6-sample box -> next cycle validSamp_R14H=0, halt_RnnnnL=1, and outputs are 0.
